// File: rtl/pipe_pkg.sv
// Shared pipeline types: datapath width, control-bundle bit positions, ALUOp codes.
// Pure declarations, no timing; no backpressure.
package pipe_pkg;

    localparam int XLEN   = 64;
    localparam int CTRL_W = 9;

    localparam int CTRL_REGWRITE  = 8;
    localparam int CTRL_MEMREAD   = 7;
    localparam int CTRL_MEMWRITE  = 6;
    localparam int CTRL_MEMTOREG  = 5;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_BRANCH    = 3;
    localparam int CTRL_JUMP      = 2;
    localparam int CTRL_ALUOP_MSB = 1;
    localparam int CTRL_ALUOP_LSB = 0;

    localparam logic [1:0] ALUOP_LOADSTORE = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE     = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE     = 2'b11;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic ctrl_t makeCtrl(input logic regWrite, input logic memRead,
                                       input logic memWrite, input logic memtoReg,
                                       input logic aluSrc, input logic branch,
                                       input logic jump, input logic [1:0] aluOp);
        ctrl_t c;
        c = CTRL_BUBBLE;
        c[CTRL_REGWRITE] = regWrite;
        c[CTRL_MEMREAD]  = memRead;
        c[CTRL_MEMWRITE] = memWrite;
        c[CTRL_MEMTOREG] = memtoReg;
        c[CTRL_ALUSRC]   = aluSrc;
        c[CTRL_BRANCH]   = branch;
        c[CTRL_JUMP]     = jump;
        c[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = aluOp;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode fields, regfile read data, WB write port, EX-side outputs.
// master = surrounding pipeline, slave = the id_ex_stage register.
interface id_ex_stage_if #(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = 32
);
    logic              flush;
    logic              idValid;
    logic [XLEN-1:0]   idPc;
    logic [4:0]        idRs1;
    logic [4:0]        idRs2;
    logic [4:0]        idRd;
    logic [XLEN-1:0]   idImm;
    logic [CTRL_W-1:0] idCtrl;
    logic [XLEN-1:0]   rfRdata1;
    logic [XLEN-1:0]   rfRdata2;
    logic              wbRegwrite;
    logic [4:0]        wbRd;
    logic [XLEN-1:0]   wbData;

    logic              stall;
    logic              exValid;
    logic [XLEN-1:0]   exPc;
    logic [XLEN-1:0]   exImm;
    logic [XLEN-1:0]   exRs1Data;
    logic [XLEN-1:0]   exRs2Data;
    logic [4:0]        exRs1;
    logic [4:0]        exRs2;
    logic [4:0]        exRd;
    logic [CTRL_W-1:0] exCtrl;
    logic [CNT_W-1:0]  bubbleCnt;
    logic [CNT_W-1:0]  flushCnt;

    modport master (
        output flush, idValid, idPc, idRs1, idRs2, idRd, idImm, idCtrl,
               rfRdata1, rfRdata2, wbRegwrite, wbRd, wbData,
        input  stall, exValid, exPc, exImm, exRs1Data, exRs2Data,
               exRs1, exRs2, exRd, exCtrl, bubbleCnt, flushCnt
    );

    modport slave (
        input  flush, idValid, idPc, idRs1, idRs2, idRd, idImm, idCtrl,
               rfRdata1, rfRdata2, wbRegwrite, wbRd, wbData,
        output stall, exValid, exPc, exImm, exRs1Data, exRs2Data,
               exRs1, exRs2, exRd, exCtrl, bubbleCnt, flushCnt
    );
endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load sitting in EX and the ID source registers.
// Purely combinational; a redirect overrides the stall since the ID instruction dies anyway.
module hazard_detect (
    input  logic       idValid,
    input  logic       exValid,
    input  logic       exMemRead,
    input  logic       flush,
    input  logic [4:0] exRd,
    input  logic [4:0] idRs1,
    input  logic [4:0] idRs2,
    output logic       stall
);
    logic hazard;

    assign hazard = idValid && exValid && exMemRead && (exRd != 5'd0)
                 && ((exRd == idRs1) || (exRd == idRs2));
    assign stall  = hazard && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, load-use stall, bubble insertion and perf counters.
// Latency 1 cycle ID->EX; stall holds PC and IF/ID upstream for one cycle per load-use.
module id_ex_stage #(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    import pipe_pkg::*;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1Data;
        logic [XLEN-1:0]   rs2Data;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
    } exState_t;

    exState_t         exQ;
    exState_t         exNext;
    logic [CNT_W-1:0] bubbleCntQ;
    logic [CNT_W-1:0] flushCntQ;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic             stall;

    hazard_detect uHazard (
        .idValid   (bus.idValid),
        .exValid   (exQ.valid),
        .exMemRead (exQ.ctrl[CTRL_MEMREAD]),
        .flush     (bus.flush),
        .exRd      (exQ.rd),
        .idRs1     (bus.idRs1),
        .idRs2     (bus.idRs2),
        .stall     (stall)
    );

    // Regfile reads before the WB write lands, so a same-cycle writeback must be merged here.
    assign op1 = (bus.wbRegwrite && (bus.wbRd != 5'd0) && (bus.wbRd == bus.idRs1))
               ? bus.wbData : bus.rfRdata1;
    assign op2 = (bus.wbRegwrite && (bus.wbRd != 5'd0) && (bus.wbRd == bus.idRs2))
               ? bus.wbData : bus.rfRdata2;

    always_comb begin
        exNext = '0;
        if (!bus.flush && !stall && bus.idValid) begin
            exNext.valid   = 1'b1;
            exNext.pc      = bus.idPc;
            exNext.imm     = bus.idImm;
            exNext.rs1Data = op1;
            exNext.rs2Data = op2;
            exNext.rs1     = bus.idRs1;
            exNext.rs2     = bus.idRs2;
            exNext.rd      = bus.idRd;
            exNext.ctrl    = bus.idCtrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exQ        <= '0;
            bubbleCntQ <= '0;
            flushCntQ  <= '0;
        end else begin
            exQ <= exNext;
            if (bus.flush) begin
                if (flushCntQ != '1) flushCntQ <= flushCntQ + CNT_W'(1);
            end else if (stall) begin
                if (bubbleCntQ != '1) bubbleCntQ <= bubbleCntQ + CNT_W'(1);
            end
        end
    end

    assign bus.stall     = stall;
    assign bus.exValid   = exQ.valid;
    assign bus.exPc      = exQ.pc;
    assign bus.exImm     = exQ.imm;
    assign bus.exRs1Data = exQ.rs1Data;
    assign bus.exRs2Data = exQ.rs2Data;
    assign bus.exRs1     = exQ.rs1;
    assign bus.exRs2     = exQ.rs2;
    assign bus.exRd      = exQ.rd;
    assign bus.exCtrl    = exQ.ctrl;
    assign bus.bubbleCnt = bubbleCntQ;
    assign bus.flushCnt  = flushCntQ;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, reset/saturation sequences, random vs reference model.
module tb_id_ex_stage;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(32)) bus ();
    id_ex_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(2))  sbus ();

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(32)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus));
    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(2))  dutSat (.clk(clk), .rst_n(rst_n), .bus(sbus));

    localparam logic [8:0] C_ADD = makeCtrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_RTYPE);
    localparam logic [8:0] C_LD  = makeCtrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_LOADSTORE);
    localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF;

    typedef struct {
        logic        flush, valid;
        logic [63:0] pc, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [8:0]  ctrl;
        logic [63:0] rd1, rd2;
        logic        wbWe;
        logic [4:0]  wbRd;
        logic [63:0] wbData;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        stall, exValid;
        logic [8:0]  exCtrl;
        logic [63:0] d1, d2;
        int unsigned bub, fl;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [63:0] pc, imm, d1, d2;
        logic [4:0]  rs1, rs2, rd;
        logic [8:0]  ctrl;
    } exModel_t;

    int errors = 0;
    int checks = 0;
    exModel_t mEx;
    longint unsigned mBub, mFl;
    logic mStallPre;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic valid, input logic flush,
                                 input logic [4:0] rs1, input logic [63:0] rd1,
                                 input logic [4:0] rs2, input logic [63:0] rd2,
                                 input logic [4:0] rd, input logic [8:0] ctrl,
                                 input logic wbWe, input logic [4:0] wbRd, input logic [63:0] wbData);
        stim_t s;
        s.valid = valid; s.flush = flush; s.rs1 = rs1; s.rd1 = rd1; s.rs2 = rs2; s.rd2 = rd2;
        s.rd = rd; s.ctrl = ctrl; s.wbWe = wbWe; s.wbRd = wbRd; s.wbData = wbData;
        s.pc = 64'h1000 + {54'd0, rd, rs1}; s.imm = 64'hFFFF_FFFF_FFFF_FFF8;
        return s;
    endfunction

    function automatic vec_t v(input stim_t s, input logic stall, input logic exValid,
                               input logic [8:0] c, input logic [63:0] d1, input logic [63:0] d2,
                               input int unsigned bub, input int unsigned fl);
        vec_t r;
        r.s = s; r.stall = stall; r.exValid = exValid; r.exCtrl = c;
        r.d1 = d1; r.d2 = d2; r.bub = bub; r.fl = fl;
        return r;
    endfunction

    task automatic drive(input stim_t s);
        bus.flush = s.flush; bus.idValid = s.valid; bus.idPc = s.pc; bus.idImm = s.imm;
        bus.idRs1 = s.rs1; bus.idRs2 = s.rs2; bus.idRd = s.rd; bus.idCtrl = s.ctrl;
        bus.rfRdata1 = s.rd1; bus.rfRdata2 = s.rd2;
        bus.wbRegwrite = s.wbWe; bus.wbRd = s.wbRd; bus.wbData = s.wbData;
    endtask

    // Reference: the value an instruction should see for a register once WB has written it.
    function automatic logic [63:0] seen(input logic [4:0] rs, input logic [63:0] rf, input stim_t s);
        if (rs == 5'd0) return rf;
        if (s.wbWe && s.wbRd == rs) return s.wbData;
        return rf;
    endfunction

    function automatic logic modelStall(input stim_t s);
        logic needsLoad;
        needsLoad = mEx.valid && mEx.ctrl[CTRL_MEMREAD] && mEx.rd != 5'd0
                 && (mEx.rd == s.rs1 || mEx.rd == s.rs2);
        return s.valid && needsLoad && !s.flush;
    endfunction

    task automatic modelReset();
        mEx = '{default: '0};
        mBub = 0;
        mFl = 0;
    endtask

    task automatic modelEdge(input stim_t s);
        logic st;
        st = modelStall(s);
        if (s.flush) begin
            mEx = '{default: '0};
            if (mFl < CNT_MAX) mFl++;
        end else if (st) begin
            mEx = '{default: '0};
            if (mBub < CNT_MAX) mBub++;
        end else if (!s.valid) begin
            mEx = '{default: '0};
        end else begin
            mEx.valid = 1'b1; mEx.pc = s.pc; mEx.imm = s.imm;
            mEx.d1 = seen(s.rs1, s.rd1, s); mEx.d2 = seen(s.rs2, s.rd2, s);
            mEx.rs1 = s.rs1; mEx.rs2 = s.rs2; mEx.rd = s.rd; mEx.ctrl = s.ctrl;
        end
    endtask

    // Called #1 after a posedge: drive, check stall, clock, advance model.
    task automatic step(input stim_t s, output logic stallSeen);
        drive(s);
        #1;
        stallSeen = bus.stall;
        mStallPre = modelStall(s);
        chk("stall_model", {63'd0, stallSeen}, {63'd0, mStallPre});
        @(posedge clk);
        modelEdge(s);
        #1;
    endtask

    task automatic compareModel(input string tag);
        chk({tag, "_exValid"},   {63'd0, bus.exValid}, {63'd0, mEx.valid});
        chk({tag, "_exPc"},      bus.exPc, mEx.pc);
        chk({tag, "_exImm"},     bus.exImm, mEx.imm);
        chk({tag, "_exRs1Data"}, bus.exRs1Data, mEx.d1);
        chk({tag, "_exRs2Data"}, bus.exRs2Data, mEx.d2);
        chk({tag, "_exIdx"},     {49'd0, bus.exRs1, bus.exRs2, bus.exRd}, {49'd0, mEx.rs1, mEx.rs2, mEx.rd});
        chk({tag, "_exCtrl"},    {55'd0, bus.exCtrl}, {55'd0, mEx.ctrl});
        chk({tag, "_bubbleCnt"}, {32'd0, bus.bubbleCnt}, mBub);
        chk({tag, "_flushCnt"},  {32'd0, bus.flushCnt}, mFl);
    endtask

    initial begin
        stim_t s, rs, ldx7, addx7;
        logic st;

        tbl[0]  = v(mk(1,0, 5,64'h1111, 6,64'h2222, 8,C_ADD, 0,0,0),           0,1,C_ADD, 64'h1111,64'h2222, 0,0);
        tbl[1]  = v(mk(1,0, 5,64'h1111, 6,64'h2222, 8,C_ADD, 1,5,64'hDEAD),    0,1,C_ADD, 64'hDEAD,64'h2222, 0,0);
        tbl[2]  = v(mk(1,0, 0,0, 0,0, 8,C_ADD, 1,0,64'hDEAD),                  0,1,C_ADD, 0,0, 0,0);
        tbl[3]  = v(mk(1,0, 3,64'h33, 9,64'h99, 8,C_ADD, 1,9,64'hBEEF),        0,1,C_ADD, 64'h33,64'hBEEF, 0,0);
        tbl[4]  = v(mk(1,0, 3,64'h33, 9,64'h99, 8,C_ADD, 0,3,64'hBAD),         0,1,C_ADD, 64'h33,64'h99, 0,0);
        tbl[5]  = v(mk(1,0, 2,64'h1000, 0,0, 7,C_LD, 0,0,0),                   0,1,C_LD,  64'h1000,0, 0,0);
        tbl[6]  = v(mk(1,0, 1,64'h11, 7,64'h77, 10,C_ADD, 0,0,0),              1,0,CTRL_BUBBLE, 0,0, 1,0);
        tbl[7]  = v(mk(1,0, 1,64'h11, 7,64'h77, 10,C_ADD, 0,0,0),              0,1,C_ADD, 64'h11,64'h77, 1,0);
        tbl[8]  = v(mk(1,0, 2,64'h1000, 0,0, 7,C_LD, 0,0,0),                   0,1,C_LD,  64'h1000,0, 1,0);
        tbl[9]  = v(mk(1,1, 7,64'h70, 1,64'h11, 10,C_ADD, 0,0,0),              0,0,CTRL_BUBBLE, 0,0, 1,1);
        tbl[10] = v(mk(0,0, 7,64'h70, 1,64'h11, 10,C_ADD, 0,0,0),              0,0,CTRL_BUBBLE, 0,0, 1,1);
        tbl[11] = v(mk(1,0, 2,64'h1000, 0,0, 0,C_LD, 0,0,0),                   0,1,C_LD,  64'h1000,0, 1,1);
        tbl[12] = v(mk(1,0, 0,0, 0,0, 10,C_ADD, 0,0,0),                        0,1,C_ADD, 0,0, 1,1);
        tbl[13] = v(mk(1,0, 2,64'h1000, 0,0, 7,C_LD, 0,0,0),                   0,1,C_LD,  64'h1000,0, 1,1);
        tbl[14] = v(mk(1,0, 7,64'h70, 0,0, 8,C_LD, 0,0,0),                     1,0,CTRL_BUBBLE, 0,0, 2,1);
        tbl[15] = v(mk(1,0, 7,64'h70, 0,0, 8,C_LD, 0,0,0),                     0,1,C_LD,  64'h70,0, 2,1);
        tbl[16] = v(mk(1,0, 8,64'h88, 0,0, 10,C_ADD, 0,0,0),                   1,0,CTRL_BUBBLE, 0,0, 3,1);
        tbl[17] = v(mk(1,0, 8,64'h88, 0,0, 10,C_ADD, 0,0,0),                   0,1,C_ADD, 64'h88,0, 3,1);
        tbl[18] = v(mk(1,0, 2,64'h1000, 0,0, 7,C_LD, 0,0,0),                   0,1,C_LD,  64'h1000,0, 3,1);
        tbl[19] = v(mk(0,0, 7,64'h70, 0,0, 10,C_ADD, 0,0,0),                   0,0,CTRL_BUBBLE, 0,0, 3,1);

        sbus.flush = 0; sbus.idValid = 0; sbus.idPc = 0; sbus.idImm = 0; sbus.idRs1 = 0;
        sbus.idRs2 = 0; sbus.idRd = 0; sbus.idCtrl = 0; sbus.rfRdata1 = 0; sbus.rfRdata2 = 0;
        sbus.wbRegwrite = 0; sbus.wbRd = 0; sbus.wbData = 0;

        // Reset held with a valid ID instruction present.
        rs = mk(1,0, 0,0, 0,0, 1,makeCtrl(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,ALUOP_LOADSTORE), 0,0,0);
        rs.pc = 64'h40;
        drive(rs);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_exValid", {63'd0, bus.exValid}, 64'd0);
        chk("rst_exCtrl", {55'd0, bus.exCtrl}, 64'd0);
        chk("rst_bubbleCnt", {32'd0, bus.bubbleCnt}, 64'd0);
        chk("rst_flushCnt", {32'd0, bus.flushCnt}, 64'd0);
        chk("rst_stall", {63'd0, bus.stall}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        #1;
        chk("rel_exValid", {63'd0, bus.exValid}, 64'd0);
        chk("rel_exPc", bus.exPc, 64'd0);
        @(posedge clk);
        modelEdge(rs);
        #1;
        chk("first_exPc", bus.exPc, 64'h40);
        chk("first_exValid", {63'd0, bus.exValid}, 64'd1);

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].s, st);
            chk($sformatf("vec%0d_stall", i), {63'd0, st}, {63'd0, tbl[i].stall});
            chk($sformatf("vec%0d_exValid", i), {63'd0, bus.exValid}, {63'd0, tbl[i].exValid});
            chk($sformatf("vec%0d_exCtrl", i), {55'd0, bus.exCtrl}, {55'd0, tbl[i].exCtrl});
            chk($sformatf("vec%0d_exRs1Data", i), bus.exRs1Data, tbl[i].d1);
            chk($sformatf("vec%0d_exRs2Data", i), bus.exRs2Data, tbl[i].d2);
            chk($sformatf("vec%0d_bubbleCnt", i), {32'd0, bus.bubbleCnt}, {32'd0, tbl[i].bub});
            chk($sformatf("vec%0d_flushCnt", i), {32'd0, bus.flushCnt}, {32'd0, tbl[i].fl});
        end

        // Reset asserted while a load-use stall is active.
        ldx7  = mk(1,0, 2,64'h1000, 0,0, 7,C_LD, 0,0,0);
        addx7 = mk(1,0, 1,64'h11, 7,64'h77, 10,C_ADD, 0,0,0);
        step(ldx7, st);
        drive(addx7);
        #1;
        chk("midrst_stall_before", {63'd0, bus.stall}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_stall_during", {63'd0, bus.stall}, 64'd0);
        chk("midrst_exValid", {63'd0, bus.exValid}, 64'd0);
        chk("midrst_bubbleCnt", {32'd0, bus.bubbleCnt}, 64'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_stall_after", {63'd0, bus.stall}, 64'd0);
        @(posedge clk);
        modelEdge(addx7);
        #1;
        chk("midrst_add_valid", {63'd0, bus.exValid}, 64'd1);
        chk("midrst_add_rs2", bus.exRs2Data, 64'h77);
        compareModel("midrst");

        for (int n = 0; n < 400; n++) begin
            s.valid  = ($urandom_range(0, 9) < 8);
            s.flush  = ($urandom_range(0, 9) == 0);
            s.rs1    = 5'($urandom_range(0, 7));
            s.rs2    = 5'($urandom_range(0, 7));
            s.rd     = 5'($urandom_range(0, 7));
            s.ctrl   = 9'($urandom_range(0, 511));
            s.ctrl[CTRL_MEMREAD] = ($urandom_range(0, 9) < 4);
            s.pc     = {$urandom, $urandom};
            s.imm    = {$urandom, $urandom};
            s.rd1    = (s.rs1 == 0) ? 64'd0 : {$urandom, $urandom};
            s.rd2    = (s.rs2 == 0) ? 64'd0 : {$urandom, $urandom};
            s.wbWe   = $urandom_range(0, 1) == 1;
            s.wbRd   = 5'($urandom_range(0, 7));
            s.wbData = {$urandom, $urandom};
            step(s, st);
            compareModel($sformatf("rnd%0d", n));
        end

        // Saturation on a 2-bit counter instance: max value is 3.
        for (int k = 0; k < 5; k++) begin
            sbus.flush = 0; sbus.idValid = 1; sbus.idRs1 = 0; sbus.idRs2 = 0;
            sbus.idRd = 7; sbus.idCtrl = C_LD;
            @(posedge clk); #1;
            sbus.idRs1 = 7; sbus.idRd = 9; sbus.idCtrl = C_ADD;
            #1;
            chk($sformatf("sat_stall%0d", k), {63'd0, sbus.stall}, 64'd1);
            @(posedge clk); #1;
            if (k == 2) chk("sat_bubble_reach", {62'd0, sbus.bubbleCnt}, 64'd3);
        end
        chk("sat_bubble_hold", {62'd0, sbus.bubbleCnt}, 64'd3);
        sbus.flush = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("sat_flush_hold", {62'd0, sbus.flushCnt}, 64'd3);
        chk("sat_bubble_after_flush", {62'd0, sbus.bubbleCnt}, 64'd3);
        chk("sat_flush_stall", {63'd0, sbus.stall}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
